inst_mem_loader: RTL and testbench
==================================

// Module: inst_mem_loader
// PURPOSE
//  Write-side companion of the byte-addressed instruction memory. Accepts 32-bit
//  instruction words over a valid/ready stream and writes each word as 4 big-endian
//  bytes (addr+0 = bits[31:24] ... addr+3 = bits[7:0]), which is the order the fetch
//  side reassembles. Holds the core in stall (cpu_hold) for the whole load.
// PARAMETERS
//  DEPTH_BYTES  72  instruction memory size in bytes; must be a multiple of 4
//  BASE_ADDR    0   first byte address written after start
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  start      in   1   1-cycle pulse: begin a load at BASE_ADDR
//  wr_valid   in   1   wr_data/wr_last valid
//  wr_ready   out  1   loader accepts a word this cycle
//  wr_data    in   32  instruction word
//  wr_last    in   1   final word of the program
//  mem_we     out  1   byte write strobe to instruction memory
//  mem_addr   out  32  byte address
//  mem_wdata  out  8   byte to write
//  cpu_hold   out  1   stall/reset hold for the core while loading
//  done       out  1   1-cycle pulse at end of load
//  err        out  1   sticky overflow flag, cleared by the next start
//  checksum   out  8   (CHECKSUM_EN only) mod-256 sum of bytes written
// BEHAVIOUR
//  - Reset: state=IDLE; wr_ready, mem_we, cpu_hold, done, err=0; mem_addr=BASE_ADDR;
//    mem_wdata=0; checksum=0. Reset mid-load aborts at once; bytes already written stay.
//  - States: IDLE -> LOAD -> WRITE(byte 0..3) -> LOAD | DONE -> IDLE.
//  - IDLE: cpu_hold=0. On start: addr<=BASE_ADDR, err<=0, checksum<=0, go LOAD.
//  - LOAD: cpu_hold=1. wr_ready=1 iff addr+4 <= DEPTH_BYTES. Handshake (valid&ready):
//    latch word and last flag, go WRITE with byte index 0. wr_valid=1 while no room:
//    err<=1, go DONE; the word is not accepted.
//  - WRITE: 4 cycles, registered outputs. Cycle k (k=0..3): mem_we=1,
//    mem_addr=addr+k, mem_wdata=word[31-8k -: 8]. wr_ready=0.
//    After k=3: addr<=addr+4. Go DONE if latched last=1, else LOAD.
//  - Throughput: 1 word per 5 cycles. First mem_we is 1 cycle after the handshake.
//  - DONE: done=1 for exactly one cycle, cpu_hold still 1. Next cycle IDLE, cpu_hold=0.
//  - start outside IDLE: ignored. wr_valid outside LOAD: ignored, no handshake.
//  - mem_we=0 in every state other than WRITE. mem_addr/mem_wdata hold last value.
//  - Address arithmetic is 32-bit unsigned. No wrap: the room check blocks overflow.
// CONFIGURATION
//  CHECKSUM_EN defined: checksum port exists. It accumulates mem_wdata on each
//    mem_we cycle (mod 256), is cleared on start, and is stable from DONE until the next start.
//  CHECKSUM_EN undefined: checksum port and adder are absent. All other behaviour is
//    identical.
// TESTING
//  1. start; 2 words 0xE3A00014, 0xE3A01A01 (last on 2nd) -> writes at addr 0..7:
//     E3,A0,00,14,E3,A0,1A,01; done pulse; cpu_hold falls the cycle after done.
//  2. DEPTH_BYTES=8, 3 words, no last -> 2 words written, wr_ready=0 at addr 8,
//     err=1, done pulse, addr 8 never written.
//  3. wr_valid toggling 1/0 every cycle -> only handshaked words written, in order,
//     and mem_we count = 4 x handshakes.
//  4. Assert rst during WRITE byte 2 -> next edge: mem_we=0, cpu_hold=0, state IDLE.
//     A new start reloads from BASE_ADDR.
//  5. start pulse during LOAD, and wr_valid in IDLE -> no effect; no mem_we in IDLE.
//  6. CHECKSUM_EN, words 0x01020304, 0xFFFFFFFF last -> checksum=0x06.

Source files
------------

// File: rtl/inst_mem_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory, big-endian, holding the core in stall.
// Optional feature: define CHECKSUM_EN to add the mod-256 byte checksum output.
module inst_mem_loader #(
    parameter int unsigned DEPTH_BYTES = 72,
    parameter logic [31:0] BASE_ADDR   = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    input  logic        wr_last,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        cpu_hold,
    output logic        done,
`ifdef CHECKSUM_EN
    output logic [7:0]  checksum,
`endif
    output logic        err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  idx_q, idx_d;
    logic        err_q, err_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic [31:0] word_q, word_d;
    logic        last_q, last_d;
    logic [1:0]  idx_next;
    logic [31:0] word_shift;
    logic        room;

    // 33-bit compare so a BASE_ADDR near the top of the space cannot wrap the room check
    assign room       = ({1'b0, addr_q} + 33'd4) <= 33'(DEPTH_BYTES);
    assign idx_next   = idx_q + 2'd1;
    assign word_shift = word_q << {idx_next, 3'b000};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        idx_d       = idx_q;
        err_d       = err_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        word_d      = word_q;
        last_d      = last_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = BASE_ADDR;
                    err_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (wr_valid && room) begin
                    word_d      = wr_data;
                    last_d      = wr_last;
                    idx_d       = 2'd0;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = wr_data[31:24];
                    state_d     = S_WRITE;
                end else if (wr_valid) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WRITE: begin
                // idx_q is the byte currently on the memory port; stage the following one
                if (idx_q != 2'd3) begin
                    idx_d       = idx_next;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q + {30'd0, idx_next};
                    mem_wdata_d = word_shift[31:24];
                end else begin
                    addr_d  = addr_q + 32'd4;
                    state_d = last_q ? S_DONE : S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= BASE_ADDR;
            idx_q       <= 2'd0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        word_q <= word_d;
        last_q <= last_d;
    end

`ifdef CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    // The byte on the port is added at the edge that retires it, so the sum is final on entry to DONE
    always_comb begin
        csum_d = csum_q;
        if (mem_we_q) begin
            csum_d = csum_q + mem_wdata_q;
        end
        if (state_q == S_IDLE && start) begin
            csum_d = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= 8'd0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`endif

    assign wr_ready  = (state_q == S_LOAD) && room;
    assign cpu_hold  = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: default-depth instance plus an 8-byte instance for overflow.
module tb_inst_mem_loader;

    typedef struct {
        logic [31:0]     word;
        logic            last;
        logic [0:3][7:0] b;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, wr_valid = 1'b0, wr_last = 1'b0;
    logic [31:0] wr_data = 32'd0;
    logic        wr_ready, mem_we, cpu_hold, done, err;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;

    logic        start8 = 1'b0, valid8 = 1'b0, last8 = 1'b0;
    logic [31:0] data8 = 32'd0;
    logic        wr_ready8, mem_we8, cpu_hold8, done8, err8;
    logic [31:0] mem_addr8;
    logic [7:0]  mem_wdata8;
`ifdef CHECKSUM_EN
    logic [7:0]  checksum, checksum8;
`endif

    int   checks = 0;
    int   errors = 0;
    int   we_cnt = 0;
    int   hs_cnt = 0;
    logic [31:0] exp_addr = 32'd0;
    logic [31:0] exp_addr8 = 32'd0;
    vec_t tbl[12];
    exp_t sbq[$];
    exp_t sbq8[$];
    exp_t e_m, e_8;

    always #5 clk = ~clk;

    inst_mem_loader dut (
        .clk(clk), .rst(rst), .start(start), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_last(wr_last), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done),
`ifdef CHECKSUM_EN
        .checksum(checksum),
`endif
        .err(err)
    );

    inst_mem_loader #(.DEPTH_BYTES(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .wr_valid(valid8), .wr_ready(wr_ready8),
        .wr_data(data8), .wr_last(last8), .mem_we(mem_we8), .mem_addr(mem_addr8),
        .mem_wdata(mem_wdata8), .cpu_hold(cpu_hold8), .done(done8),
`ifdef CHECKSUM_EN
        .checksum(checksum8),
`endif
        .err(err8)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endfunction

    function automatic void set_vec(input int i, input logic [31:0] w, input logic l, input logic [31:0] bytes);
        tbl[i].word = w;
        tbl[i].last = l;
        tbl[i].b    = bytes;
    endfunction

    always @(negedge clk) begin
        if (!rst && mem_we) begin
            we_cnt++;
            chk("hold_during_write", {31'd0, cpu_hold}, 32'd1);
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %h data %h, expected no write", mem_addr, mem_wdata);
            end else begin
                e_m = sbq.pop_front();
                chk("write_addr", mem_addr, e_m.addr);
                chk("write_data", {24'd0, mem_wdata}, {24'd0, e_m.data});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && mem_we8) begin
            if (sbq8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write8: addr %h data %h, expected no write", mem_addr8, mem_wdata8);
            end else begin
                e_8 = sbq8.pop_front();
                chk("write8_addr", mem_addr8, e_8.addr);
                chk("write8_data", {24'd0, mem_wdata8}, {24'd0, e_8.data});
            end
        end
    end

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        exp_addr = 32'd0;
    endtask

    task automatic run_prog(input int first, input int n, input bit toggle);
        int idx = first;
        int cyc = 0;
        while (idx < first + n && cyc < 200) begin
            @(posedge clk); #1;
            wr_valid = toggle ? ~cyc[0] : 1'b1;
            wr_data  = tbl[idx].word;
            wr_last  = tbl[idx].last;
            @(negedge clk);
            if (wr_valid && wr_ready) begin
                for (int k = 0; k < 4; k++) sbq.push_back('{exp_addr + 32'(k), tbl[idx].b[k]});
                exp_addr += 32'd4;
                idx++;
                hs_cnt++;
            end
            cyc++;
        end
        chk("load_complete", 32'(idx), 32'(first + n));
        @(posedge clk); #1;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        chk("we_after_handshake", {31'd0, mem_we}, 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("hold_in_done", {31'd0, cpu_hold}, 32'd1);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("hold_released", {31'd0, cpu_hold}, 32'd0);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, n, hs8, bad, idx8;
        set_vec(0,  32'hE3A00014, 1'b0, {8'hE3, 8'hA0, 8'h00, 8'h14});
        set_vec(1,  32'hE3A01A01, 1'b1, {8'hE3, 8'hA0, 8'h1A, 8'h01});
        set_vec(2,  32'h11223344, 1'b0, {8'h11, 8'h22, 8'h33, 8'h44});
        set_vec(3,  32'h55667788, 1'b0, {8'h55, 8'h66, 8'h77, 8'h88});
        set_vec(4,  32'h99AABBCC, 1'b1, {8'h99, 8'hAA, 8'hBB, 8'hCC});
        set_vec(5,  32'hDEADBEEF, 1'b0, {8'hDE, 8'hAD, 8'hBE, 8'hEF});
        set_vec(6,  32'h0BADF00D, 1'b1, {8'h0B, 8'hAD, 8'hF0, 8'h0D});
        set_vec(7,  32'h01020304, 1'b0, {8'h01, 8'h02, 8'h03, 8'h04});
        set_vec(8,  32'hFFFFFFFF, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hFF});
        set_vec(9,  32'hA1A2A3A4, 1'b0, {8'hA1, 8'hA2, 8'hA3, 8'hA4});
        set_vec(10, 32'hB1B2B3B4, 1'b0, {8'hB1, 8'hB2, 8'hB3, 8'hB4});
        set_vec(11, 32'hC1C2C3C4, 1'b0, {8'hC1, 8'hC2, 8'hC3, 8'hC4});

        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
`ifdef CHECKSUM_EN
        chk("rst_checksum", {24'd0, checksum}, 32'd0);
`endif
        rst = 1'b0;

        // two-word program, last on the second word
        do_start();
        @(negedge clk);
        chk("load_hold", {31'd0, cpu_hold}, 32'd1);
        chk("load_ready", {31'd0, wr_ready}, 32'd1);
        run_prog(0, 2, 1'b0);
        wait_done();
        chk("err_clean", {31'd0, err}, 32'd0);

        // wr_valid toggling every cycle
        w0 = we_cnt;
        hs_cnt = 0;
        do_start();
        run_prog(2, 3, 1'b1);
        wait_done();
        chk("hs_count", 32'(hs_cnt), 32'd3);
        chk("we_count", 32'(we_cnt - w0), 32'(4 * hs_cnt));

        // reset while byte 2 of a word is on the port
        do_start();
        wr_valid = 1'b1;
        wr_data  = 32'hCAFEBABE;
        wr_last  = 1'b1;
        @(negedge clk);
        chk("rst_seq_ready", {31'd0, wr_ready}, 32'd1);
        sbq.push_back('{32'd0, 8'hCA});
        sbq.push_back('{32'd1, 8'hFE});
        sbq.push_back('{32'd2, 8'hBA});
        @(posedge clk); #1 wr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("at_byte2", mem_addr, 32'd2);
        #1 rst = 1'b1;
        #1;
        chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
        chk("abort_hold", {31'd0, cpu_hold}, 32'd0);
        chk("abort_addr", mem_addr, 32'd0);
        @(negedge clk) rst = 1'b0;
        wr_last = 1'b0;
        @(negedge clk);
        chk("abort_idle", {31'd0, cpu_hold}, 32'd0);
        chk("abort_sb", 32'(sbq.size()), 32'd0);
        do_start();
        run_prog(0, 2, 1'b0);
        wait_done();

        // wr_valid in IDLE and start during LOAD are ignored
        w0 = we_cnt;
        wr_valid = 1'b1;
        wr_data  = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_ready", {31'd0, wr_ready}, 32'd0);
            chk("idle_hold", {31'd0, cpu_hold}, 32'd0);
        end
        wr_valid = 1'b0;
        chk("idle_no_we", 32'(we_cnt - w0), 32'd0);
        do_start();
        run_prog(5, 1, 1'b0);
        n = 0;
        @(negedge clk);
        while (!wr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("back_to_load", {31'd0, wr_ready}, 32'd1);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        run_prog(6, 1, 1'b0);
        wait_done();

`ifdef CHECKSUM_EN
        do_start();
        run_prog(7, 2, 1'b0);
        wait_done();
        chk("checksum", {24'd0, checksum}, 32'h06);
        @(negedge clk);
        chk("checksum_stable", {24'd0, checksum}, 32'h06);
`endif

        // overflow on the 8-byte instance
        @(posedge clk); #1 start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        exp_addr8 = 32'd0;
        hs8  = 0;
        bad  = 0;
        idx8 = 9;
        valid8 = 1'b1;
        data8  = tbl[idx8].word;
        last8  = 1'b0;
        n = 0;
        @(negedge clk);
        while (!done8 && n < 60) begin
            if (exp_addr8 >= 32'd8 && wr_ready8) bad = 1;
            if (valid8 && wr_ready8) begin
                for (int k = 0; k < 4; k++) sbq8.push_back('{exp_addr8 + 32'(k), tbl[idx8].b[k]});
                exp_addr8 += 32'd4;
                hs8++;
                @(posedge clk); #1;
                idx8  = (idx8 < 11) ? idx8 + 1 : 11;
                data8 = tbl[idx8].word;
            end
            @(negedge clk);
            n++;
        end
        chk("ovf_done", {31'd0, done8}, 32'd1);
        chk("ovf_words", 32'(hs8), 32'd2);
        chk("ovf_err", {31'd0, err8}, 32'd1);
        chk("ovf_no_ready_full", 32'(bad), 32'd0);
        chk("ovf_hold", {31'd0, cpu_hold8}, 32'd1);
        valid8 = 1'b0;
        @(negedge clk);
        chk("ovf_done_pulse", {31'd0, done8}, 32'd0);
        chk("ovf_hold_released", {31'd0, cpu_hold8}, 32'd0);
        chk("ovf_err_sticky", {31'd0, err8}, 32'd1);
        chk("ovf_sb", 32'(sbq8.size()), 32'd0);
        @(posedge clk); #1 start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        @(negedge clk);
        chk("err_cleared_by_start", {31'd0, err8}, 32'd0);

        chk("final_sb", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
